// File: rtl/pool_pkg.sv
// pool_pkg: state encoding and parameter defaults shared by the 2x2 average-pool controller
package pool_pkg;
  typedef enum logic [2:0] {IDLE, RD, LAST, WR, DONE} state_t;
  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_IN_W = 28;
  localparam int DEF_IN_H = 28;
  localparam int DEF_ADDR_W = 10;
endpackage

// File: rtl/pool_if.sv
// pool_if: start/status handshake plus input-map read port and output-map write port
interface pool_if import pool_pkg::*; #(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic start;
  logic busy;
  logic done;
  logic [ADDR_W-1:0] rd_addr;
  logic signed [WORD_SIZE-1:0] rd_data;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic signed [WORD_SIZE-1:0] wr_data;
  modport master (input start, rd_data, output busy, done, rd_addr, wr_en, wr_addr, wr_data);
  modport slave (output start, rd_data, input busy, done, rd_addr, wr_en, wr_addr, wr_data);
endinterface

// File: rtl/pool_addr_gen.sv
// pool_addr_gen: window (r,c) and read-phase k counters with row-major read/write address decode
module pool_addr_gen #(
  parameter int IN_W = 28,
  parameter int IN_H = 28,
  parameter int ADDR_W = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_rd,
  input  logic i_wr,
  output logic [1:0] o_k,
  output logic [ADDR_W-1:0] o_rd_addr,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic o_last
);
  localparam logic [ADDR_W-1:0] LW = ADDR_W'(IN_W);
  localparam logic [ADDR_W-1:0] LHW = ADDR_W'(IN_W / 2);
  localparam logic [ADDR_W-1:0] LC = ADDR_W'(IN_W / 2 - 1);
  localparam logic [ADDR_W-1:0] LR = ADDR_W'(IN_H / 2 - 1);
  logic [ADDR_W-1:0] r_r, r_c;
  logic [1:0] r_k;
  logic [ADDR_W-1:0] w_row, w_col;
  logic w_c_end;
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_r <= '0;
      r_c <= '0;
      r_k <= '0;
    end else if (i_rd) begin
      r_k <= r_k + 2'd1;
    end else if (i_wr) begin
      r_c <= w_c_end ? '0 : r_c + ADDR_W'(1);
      r_r <= o_last ? '0 : (w_c_end ? r_r + ADDR_W'(1) : r_r);
    end
  end
  // k[1] selects the lower row of the window, k[0] the right column
  always_comb begin
    w_c_end = r_c == LC;
    w_row = (r_r << 1) + ADDR_W'(r_k[1]);
    w_col = (r_c << 1) + ADDR_W'(r_k[0]);
    o_k = r_k;
    o_last = w_c_end && r_r == LR;
    o_rd_addr = i_rd ? w_row * LW + w_col : '0;
    o_wr_addr = i_wr ? r_r * LHW + r_c : '0;
  end
endmodule

// File: rtl/pool_ctrl.sv
// pool_ctrl: 2x2 average pooling over a row-major input map, one window every 6 cycles
module pool_ctrl import pool_pkg::*; #(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int IN_W = DEF_IN_W,
  parameter int IN_H = DEF_IN_H,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input logic clk,
  input logic reset,
  pool_if.master bus
);
  state_t r_state, w_next;
  logic signed [WORD_SIZE+1:0] r_acc, w_px;
  logic [1:0] w_k;
  logic w_last;
  logic [ADDR_W-1:0] w_rd_addr, w_wr_addr;
  pool_addr_gen #(.IN_W(IN_W), .IN_H(IN_H), .ADDR_W(ADDR_W)) u_addr (
    .clk(clk),
    .reset(reset),
    .i_clr(r_state == IDLE),
    .i_rd(r_state == RD),
    .i_wr(r_state == WR),
    .o_k(w_k),
    .o_rd_addr(w_rd_addr),
    .o_wr_addr(w_wr_addr),
    .o_last(w_last)
  );
  always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
  // read data trails the address by one cycle, so pixels land at k=1..3 and LAST
  always_ff @(posedge clk) begin
    if (reset) r_acc <= '0;
    else if (r_state == RD && w_k == 2'd1) r_acc <= w_px;
    else if ((r_state == RD && w_k[1]) || r_state == LAST) r_acc <= r_acc + w_px;
  end
  always_comb begin
    w_next = r_state;
    w_px = {{2{bus.rd_data[WORD_SIZE-1]}}, bus.rd_data};
    unique case (r_state)
      IDLE: w_next = bus.start ? RD : IDLE;
      RD: w_next = w_k == 2'd3 ? LAST : RD;
      LAST: w_next = WR;
      WR: w_next = w_last ? DONE : RD;
      default: w_next = IDLE;
    endcase
    bus.busy = r_state != IDLE;
    bus.done = r_state == DONE;
    bus.wr_en = r_state == WR;
    bus.rd_addr = w_rd_addr;
    bus.wr_addr = w_wr_addr;
    bus.wr_data = r_state == WR ? r_acc[WORD_SIZE+1:2] : '0;
  end
endmodule

// File: tb/tb_pool_ctrl.sv
// tb_pool_ctrl: directed scoreboard bench on a 4x4 map (pass/abort/timing) and a 2x2 map (rounding/limits)
module tb_pool_ctrl;
  typedef struct {int addr; int data;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0;
  int bad = 0;
  exp_t qa[$];
  exp_t qb[$];
  logic signed [15:0] mem_a [16];
  logic signed [15:0] mem_b [4];

  pool_if #(.WORD_SIZE(16), .ADDR_W(4)) ba();
  pool_if #(.WORD_SIZE(16), .ADDR_W(2)) bb();

  pool_ctrl #(.WORD_SIZE(16), .IN_W(4), .IN_H(4), .ADDR_W(4)) dut_a (.clk(clk), .reset(reset), .bus(ba));
  pool_ctrl #(.WORD_SIZE(16), .IN_W(2), .IN_H(2), .ADDR_W(2)) dut_b (.clk(clk), .reset(reset), .bus(bb));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    ba.rd_data <= mem_a[ba.rd_addr];
    bb.rd_data <= mem_b[bb.rd_addr];
  end

  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (ba.wr_en === 1'b1) begin
      if (qa.size() == 0) chk("a_unexpected_wr", 32'(ba.wr_addr), -1);
      else begin
        e = qa.pop_front();
        chk("a_wr_addr", 32'(ba.wr_addr), e.addr);
        chk("a_wr_data", 32'(ba.wr_data), e.data);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (bb.wr_en === 1'b1) begin
      if (qb.size() == 0) chk("b_unexpected_wr", 32'(bb.wr_addr), -1);
      else begin
        e = qb.pop_front();
        chk("b_wr_addr", 32'(bb.wr_addr), e.addr);
        chk("b_wr_data", 32'(bb.wr_data), e.data);
      end
    end
  end

  task automatic push_a();
    int s;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        s = int'(mem_a[8*r+2*c]) + int'(mem_a[8*r+2*c+1]) + int'(mem_a[8*r+4+2*c]) + int'(mem_a[8*r+4+2*c+1]);
        qa.push_back('{r * 2 + c, s >>> 2});
      end
  endtask

  task automatic pass_a(input bit hold);
    int seen = 0;
    int at = -1;
    ba.start = 1'b1;
    for (int j = 1; j <= 27; j++) begin
      @(negedge clk);
      if (!hold || j == 26) ba.start = 1'b0;
      if (j == 1) chk("a_busy_first", 32'(ba.busy), 1);
      if (ba.done === 1'b1) begin
        seen++;
        at = j;
      end
    end
    chk("a_done_count", seen, 1);
    chk("a_done_cycle", at, 25);
    chk("a_idle_after", 32'(ba.busy), 0);
    chk("a_queue_left", qa.size(), 0);
  endtask

  task automatic pass_b(input logic signed [15:0] p0, p1, p2, p3, input int exp);
    int seen = 0;
    int at = -1;
    mem_b[0] = p0;
    mem_b[1] = p1;
    mem_b[2] = p2;
    mem_b[3] = p3;
    qb.push_back('{0, exp});
    bb.start = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      @(negedge clk);
      bb.start = 1'b0;
      if (bb.done === 1'b1) begin
        seen++;
        at = j;
      end
    end
    chk("b_done_count", seen, 1);
    chk("b_done_cycle", at, 7);
    chk("b_queue_left", qb.size(), 0);
  endtask

  initial begin
    int quiet;
    ba.start = 1'b0;
    bb.start = 1'b0;
    for (int i = 0; i < 16; i++) mem_a[i] = '0;
    for (int i = 0; i < 4; i++) mem_b[i] = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(ba.busy), 0);
    chk("rst_done", 32'(ba.done), 0);
    chk("rst_wr_en", 32'(ba.wr_en), 0);
    chk("rst_rd_addr", 32'(ba.rd_addr), 0);
    chk("rst_wr_addr", 32'(ba.wr_addr), 0);
    chk("rst_wr_data", 32'(ba.wr_data), 0);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) mem_a[i] = 16'sd4;
    for (int i = 0; i < 4; i++) qa.push_back('{i, 4});
    pass_a(1'b0);
    for (int i = 0; i < 16; i++) mem_a[i] = 16'(i);
    qa.push_back('{0, 2});
    qa.push_back('{1, 4});
    qa.push_back('{2, 10});
    qa.push_back('{3, 12});
    pass_a(1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("hold_no_restart", 32'(ba.busy), 0);
    end
    reset = 1'b1;
    ba.start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    ba.start = 1'b0;
    chk("rst_over_start", 32'(ba.busy), 0);
    @(negedge clk);
    chk("rst_over_start2", 32'(ba.busy), 0);
    for (int i = 0; i < 16; i++) mem_a[i] = 16'($urandom);
    push_a();
    ba.start = 1'b1;
    @(negedge clk);
    ba.start = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_rd_addr_k2", 32'(ba.rd_addr), 6);
    chk("abort_q_before", qa.size(), 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(ba.busy), 0);
    chk("abort_wr_en", 32'(ba.wr_en), 0);
    chk("abort_rd_addr", 32'(ba.rd_addr), 0);
    chk("abort_wr_data", 32'(ba.wr_data), 0);
    qa.delete();
    quiet = 0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (ba.done !== 1'b0 || ba.busy !== 1'b0) quiet++;
    end
    chk("abort_quiet", quiet, 0);
    for (int i = 0; i < 16; i++) mem_a[i] = 16'($urandom);
    push_a();
    pass_a(1'b0);
    pass_b(-16'sd1, -16'sd1, -16'sd1, -16'sd2, -2);
    pass_b(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 32767);
    pass_b(16'sh8000, 16'sh8000, 16'sh8000, 16'sh8000, -32768);
    pass_b(-16'sd3, 16'sd0, 16'sd0, 16'sd0, -1);
    pass_b(16'sd3, 16'sd0, 16'sd0, 16'sd0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pool_ctrl.md
POOL_CTRL -- requirements
Module: pool_ctrl

Interface
REQ-001 Parameter WORD_SIZE, default 16: signed pixel width, two's complement.
REQ-002 Parameter IN_W, default 28: input feature-map width in pixels; must be even.
REQ-003 Parameter IN_H, default 28: input feature-map height in pixels; must be even.
REQ-004 Parameter ADDR_W, default 10: address width; 2^ADDR_W >= IN_W*IN_H.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request one full pooling pass; sampled only in IDLE.
REQ-008 busy  output  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
REQ-009 done  output  1  one-cycle pulse at the end of a pass.
REQ-010 rd_addr  output  ADDR_W  input-map read address, row-major (row*IN_W + col).
REQ-011 rd_data  input  WORD_SIZE  signed pixel; returns mem[rd_addr] exactly one cycle after the address is presented.
REQ-012 wr_en  output  1  output-map write strobe.
REQ-013 wr_addr  output  ADDR_W  output-map address, row-major (r*(IN_W/2) + c).
REQ-014 wr_data  output  WORD_SIZE  signed 2x2 average.

Function
REQ-015 The FSM SHALL have states IDLE, RD, LAST, WR and DONE.
REQ-016 IDLE SHALL move to RD on start=1; start SHALL be ignored in every other state.
REQ-017 RD SHALL last 4 cycles (k=0..3), presenting rd_addr = a0, a1, b0, b1 in turn.
REQ-018 For window (r,c): a0=(2r,2c), a1=(2r,2c+1), b0=(2r+1,2c), b1=(2r+1,2c+1).
REQ-019 Windows SHALL be visited row-major over the output map, r = 0..IN_H/2-1 and c = 0..IN_W/2-1.
REQ-020 The accumulator SHALL be a signed WORD_SIZE+2-bit register.
REQ-021 The accumulator SHALL load the sign-extended rd_data at RD k=1 and add the sign-extended rd_data at RD k=2, RD k=3 and LAST.
REQ-022 LAST SHALL last one cycle and then move to WR.
REQ-023 WR SHALL last one cycle with wr_en=1, wr_addr = the window index, and wr_data = bits [WORD_SIZE-1:0] of (accumulator >>> 2), i.e. floor of the mean; overflow is impossible.
REQ-024 After WR, the FSM SHALL go to RD for the next window, or to DONE if the window just written was (IN_H/2-1, IN_W/2-1).
REQ-025 DONE SHALL last one cycle with done=1 and then return to IDLE; a start asserted during DONE SHALL be ignored.
REQ-026 Each window SHALL take exactly 6 cycles; with start accepted at edge T, done SHALL be high in cycle T+1+6*N, where N=(IN_W/2)*(IN_H/2).
REQ-027 wr_en SHALL be high only in WR; rd_addr SHALL be 0 outside RD.
REQ-028 busy, done and wr_en SHALL be decoded from registered state only, with no combinational path from any input.

Reset
REQ-029 reset=1 SHALL force, on the next edge and in any state, state=IDLE, all counters and the accumulator to 0, and busy, done, wr_en, wr_addr, wr_data and rd_addr to 0.
REQ-030 Reset mid-pass SHALL abort the pass: no further writes and no done pulse; a later start SHALL restart at window (0,0).
REQ-031 reset SHALL take priority over start in the same cycle.

Structure
REQ-032 A shared package pool_pkg SHALL hold the state enum (IDLE, RD, LAST, WR, DONE) and the defaults for WORD_SIZE, IN_W and IN_H.
REQ-033 Address generation SHALL be one sub-module, pool_addr_gen, owning the r, c and k counters and producing rd_addr, wr_addr and a last-window flag.

Verification
REQ-034 IN_W=IN_H=4, all pixels 16'sd4, start at edge T -> four writes of 4 at wr_addr 0,1,2,3; done high only in cycle T+25.
REQ-035 Single window with pixels -1,-1,-1,-2 (sum -5) -> wr_data = -2 (floor), not -1.
REQ-036 Window of 4x32767 -> 32767; window of 4x(-32768) -> -32768; no wraparound.
REQ-037 IN_W=IN_H=4, pixel value = its own address, -> wr_data sequence 2, 4, 10, 12, confirming row-major addressing.
REQ-038 reset asserted during the second window's RD k=2 -> idle next cycle with all outputs 0; no wr_en or done afterwards; a re-start yields a complete, correct pass.
REQ-039 start held high for the whole pass and during DONE -> exactly one pass and one done pulse; a new pass begins only after IDLE samples start.
